// File: rtl/alu_cdb_stage.sv
// alu_cdb_stage: integer execute stage feeding an in-order result queue that drains onto the CDB.
// Define ALU_CDB_MUL_EN to build the pipelined 64-bit multiplier; otherwise opcode 0x08 yields 0.

module alu_cdb_stage #(
   parameter int ISSUE_W  = 2,
   parameter int CDB_W    = 2,
   parameter int PHYS_W   = 6,
   parameter int RQ_DEPTH = 8,
   parameter int MUL_LAT  = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic [ISSUE_W-1:0]             issue_valid,
   input  logic [ISSUE_W-1:0][7:0]        issue_op,
   input  logic [ISSUE_W-1:0][PHYS_W-1:0] issue_dst_tag,
   input  logic [ISSUE_W-1:0][63:0]       issue_src1_val,
   input  logic [ISSUE_W-1:0][63:0]       issue_src2_val,
   input  logic [ISSUE_W-1:0][5:0]        issue_rob_tag,
   output logic                           issue_ready,
   output logic [CDB_W-1:0]               cdb_valid,
   output logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag,
   output logic [CDB_W-1:0][63:0]         cdb_value,
   output logic [CDB_W-1:0][5:0]          cdb_rob_tag
);

   localparam int PW   = $clog2(RQ_DEPTH);
   localparam int CW   = PW + 1;
   localparam int NENQ = 2 * ISSUE_W;

   typedef struct packed {
      logic [PHYS_W-1:0] tag;
      logic [63:0]       value;
      logic [5:0]        rob;
   } result_t;

   if (MUL_LAT < 2 || RQ_DEPTH < 2 * ISSUE_W || (RQ_DEPTH & (RQ_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("alu_cdb_stage: illegal parameter combination");
   end

   function automatic logic [63:0] alu_calc(input logic [7:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
      logic [5:0] sh;
      sh = b[5:0];
      case (op)
         8'h00:   return a + b;
         8'h01:   return a - b;
         8'h02:   return a & b;
         8'h03:   return a | b;
         8'h04:   return a ^ b;
         8'h05:   return a << sh;
         8'h06:   return a >> sh;
         8'h07:   return $signed(a) >>> sh;
         default: return '0;
      endcase
   endfunction

   result_t                  rq [RQ_DEPTH];
   logic [PW-1:0]            head, tail;
   logic [CW-1:0]            count, mul_inflight, enq_cnt, deq_cnt;
   logic [ISSUE_W-1:0]       acc, is_mul, mul_exit_v;
   result_t [ISSUE_W-1:0]    alu_res, mul_exit_r;
   logic [NENQ-1:0]          cand_v;
   result_t [NENQ-1:0]       cand_r;
   logic [PW-1:0]            enq_idx [NENQ];

   // Credit ignores this cycle's dequeues so it depends on registered state only.
   assign issue_ready = (int'(count) + int'(mul_inflight) + ISSUE_W) <= RQ_DEPTH;
   assign deq_cnt     = (count > CW'(CDB_W)) ? CW'(CDB_W) : count;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      acc     = '0;
      is_mul  = '0;
      alu_res = '0;
      for (int l = 0; l < ISSUE_W; l++) begin
`ifdef ALU_CDB_MUL_EN
         is_mul[l] = (issue_op[l] == 8'h08);
`endif
         acc[l]     = issue_valid[l] & issue_ready & ~flush;
         alu_res[l] = '{tag: issue_dst_tag[l],
                        value: alu_calc(issue_op[l], issue_src1_val[l], issue_src2_val[l]),
                        rob: issue_rob_tag[l]};
      end
   end

`ifdef ALU_CDB_MUL_EN
   localparam int MS = MUL_LAT - 1;

   logic [ISSUE_W-1:0]    mp_v [MS];
   result_t [ISSUE_W-1:0] mp_r [MS];
   result_t [ISSUE_W-1:0] mul_res;
   logic [ISSUE_W-1:0]    mul_new;

   assign mul_new = acc & is_mul;

   always_comb begin
      mul_res = '0;
      for (int l = 0; l < ISSUE_W; l++)
         mul_res[l] = '{tag: issue_dst_tag[l], value: issue_src1_val[l] * issue_src2_val[l],
                        rob: issue_rob_tag[l]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush) begin
         for (int s = 0; s < MS; s++) mp_v[s] <= '0;
         mul_inflight <= '0;
      end else begin
         mp_v[0] <= mul_new;
         for (int s = 1; s < MS; s++) mp_v[s] <= mp_v[s-1];
         mul_inflight <= mul_inflight + CW'($countones(mul_new)) - CW'($countones(mp_v[MS-1]));
      end
   end

   // NOTE: payload storage carries no reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      mp_r[0] <= mul_res;
      for (int s = 1; s < MS; s++) mp_r[s] <= mp_r[s-1];
   end

   assign mul_exit_v = mp_v[MS-1];
   assign mul_exit_r = mp_r[MS-1];
`else
   assign mul_inflight = '0;
   assign mul_exit_v   = '0;
   assign mul_exit_r   = '0;
`endif

   // Candidate order: multiply exits first, then ALU lanes, each in ascending lane order.
   always_comb begin
      logic [CW-1:0] n;
      n      = '0;
      cand_v = '0;
      cand_r = '0;
      for (int l = 0; l < ISSUE_W; l++) begin
         cand_v[l]           = mul_exit_v[l];
         cand_r[l]           = mul_exit_r[l];
         cand_v[ISSUE_W + l] = acc[l] & ~is_mul[l];
         cand_r[ISSUE_W + l] = alu_res[l];
      end
      // NOTE: blocking running sum is intended; each candidate sees the slots claimed before it.
      for (int i = 0; i < NENQ; i++) begin
         enq_idx[i] = tail + n[PW-1:0];
         n          = n + CW'(cand_v[i]);
      end
      enq_cnt = n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + deq_cnt[PW-1:0];
         tail  <= tail + enq_cnt[PW-1:0];
         count <= count + enq_cnt - deq_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush)
         for (int i = 0; i < NENQ; i++)
            if (cand_v[i]) rq[enq_idx[i]] <= cand_r[i];
   end

   always_comb begin
      result_t slot;
      slot        = '0;
      cdb_valid   = '0;
      cdb_tag     = '0;
      cdb_value   = '0;
      cdb_rob_tag = '0;
      for (int b = 0; b < CDB_W; b++) begin
         slot           = rq[head + PW'(b)];
         cdb_valid[b]   = count > CW'(b);
         cdb_tag[b]     = cdb_valid[b] ? slot.tag   : '0;
         cdb_value[b]   = cdb_valid[b] ? slot.value : '0;
         cdb_rob_tag[b] = cdb_valid[b] ? slot.rob   : '0;
      end
   end

endmodule
